sc_reduce_mod_l: RTL and testbench
==================================

Name: sc_reduce_mod_l

Overview:
- Reduces a 512-bit SHAKE digest to a scalar modulo the Ed25519 group order L = 2^252 + 0x14def9dea2f79cd65812631a5cf5d3ed.
- Sits directly downstream of the SHAKE core and upstream of nonce/challenge scalar consumption in the signing FSM.
- Used for both r = H(prefix||msg) mod L and k = H(R||A||msg) mod L.
- Bit-serial, MSB-first shift-and-conditional-subtract; constant time regardless of data.

Parameters:
- DIN_W, 512, input width in bits; must be a multiple of BITS_PER_CYCLE.
- BITS_PER_CYCLE, 1, digest bits absorbed per cycle; legal values 1, 2, 4.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request pulse; sampled only in IDLE.
- din  input  DIN_W  digest, interpreted as an unsigned integer with bit DIN_W-1 as MSB; sampled only on the accepted start cycle.
- dout  output  253  din mod L; valid from done until the next accepted start.
- done  output  1  one-cycle pulse when dout is valid.
- busy  output  1  high from the cycle after start is accepted until the cycle done is asserted, inclusive.

Behaviour:
- Reset, asynchronous: state=IDLE, dout=0, done=0, busy=0, accumulator=0, shift register=0, counter=0. Reset during RUN aborts with no done pulse.
- FSM states:
  - IDLE: on start, load din into the shift register, clear the accumulator, counter=0, go to RUN.
  - RUN: each cycle take the top BITS_PER_CYCLE shift bits, shift left with zero fill, counter += 1. When counter reaches DIN_W/BITS_PER_CYCLE-1, go to FIN.
  - FIN: dout <= accumulator, done=1 for this one cycle, go to IDLE.
- Per absorbed bit b, combinational chain BITS_PER_CYCLE deep: acc' = 2*acc + b; if acc' >= L then acc' -= L.
  - Invariant acc < L, so acc' < 2L and one subtract suffices.
  - Accumulator is 254 bits internally; dout drops the top bit, which is always 0.
- Latency: start accepted at cycle 0, done at cycle DIN_W/BITS_PER_CYCLE + 1. The default is 513.
- start while busy, or in the FIN cycle: ignored; no queueing.
- start in the same cycle done pulses is impossible; done is only raised in FIN.
- start held high: the block re-triggers on the first IDLE cycle after done, by design.
- din changes after acceptance have no effect.
- Constant time: cycle count and subtract enable do not depend on data. The compare/subtract is always computed and result-muxed, never clock-gated.

Optional Feature:
- Macro: SC_REDUCE_ZEROIZE_EN.
- With it defined:
  - Adds input port zeroize (1 bit).
  - When high in any state, the next edge clears dout, accumulator, shift register and counter, and forces IDLE with no done.
  - zeroize has priority over start.
  - The signing FSM pulses zeroize in its FINISH state to scrub nonce material.
- Without it:
  - The port does not exist.
  - The shift register and accumulator keep residual values until the next start or reset.

Decomposition:
- Shared package ed25519_pkg holds:
  - the constant L (254-bit).
  - the SHAKE digest width (512).
  - the reducer state typedef (IDLE/RUN/FIN).
- ed25519_pkg is also used by the signing top and the scalar muladd unit.
- One natural sub-module: sc_reduce_step. It is combinational, computing acc_out = (2*acc_in + b) mod L for a single bit, and is instantiated BITS_PER_CYCLE times in a chain.

Test Plan:
- din=0, start → done at cycle 513, dout=0, busy high cycles 1..513.
- din=L, then din=2L → dout=0 both runs.
- din=L-1 → dout=0x1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ec.
- din=2^253 → dout=0x0fffffffffffffffffffffffffffffffeb2106215d086329a7ed9ce5a30a2c13.
- din=5L+7 → dout=7.
- Pulse start again at cycle 100 with different din → ignored, original result returned at 513.
- Assert rst_n=0 at cycle 200 → no done, all outputs 0.
- Random 512-bit din vs reference model, BITS_PER_CYCLE=1,2,4; done cycle = 513/257/129.
- With SC_REDUCE_ZEROIZE_EN: zeroize at cycle 300 → IDLE next cycle, dout=0, no done.
- With SC_REDUCE_ZEROIZE_EN: zeroize and start together in IDLE → stays IDLE.

Source files
------------

// File: rtl/ed25519_pkg.sv
// Shared Ed25519 constants and types: group order L, SHAKE digest width and
// the scalar reducer state encoding.
package ed25519_pkg;

    localparam int SHAKE_W = 512;
    localparam int SC_W    = 254;

    // L = 2^252 + 0x14def9dea2f79cd65812631a5cf5d3ed
    localparam logic [SC_W-1:0] SC_L =
        254'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed;

    typedef enum logic [1:0] {
        RED_IDLE = 2'd0,
        RED_RUN  = 2'd1,
        RED_FIN  = 2'd2
    } red_state_e;

endpackage

// File: rtl/sc_reduce_step.sv
// One bit of MSB-first modular reduction: acc_out = (2*acc_in + b) mod L.
// Requires acc_in < L, so a single conditional subtract is enough.
module sc_reduce_step
    import ed25519_pkg::*;
(
    input  logic [SC_W-1:0] acc_in,
    input  logic            b,
    output logic [SC_W-1:0] acc_out
);

    logic [SC_W:0] dbl_s;
    logic [SC_W:0] diff_s;
    logic          ge_s;

    assign dbl_s  = {acc_in, b};
    assign diff_s = dbl_s - {1'b0, SC_L};
    assign ge_s   = (dbl_s >= {1'b0, SC_L});

    // Both candidates are always formed; only the mux select depends on data.
    assign acc_out = SC_W'(ge_s ? diff_s : dbl_s);

endmodule

// File: rtl/sc_reduce_mod_l.sv
// Bit-serial reduction of a SHAKE digest modulo the Ed25519 group order L.
// Optional build macro SC_REDUCE_ZEROIZE_EN adds a scrubbing zeroize input.
module sc_reduce_mod_l
    import ed25519_pkg::*;
#(
    parameter int DIN_W          = SHAKE_W,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIN_W-1:0] din,
`ifdef SC_REDUCE_ZEROIZE_EN
    input  logic             zeroize,
`endif
    output logic [252:0]     dout,
    output logic             done,
    output logic             busy
);

    localparam int NSTEPS = DIN_W / BITS_PER_CYCLE;
    localparam int CNT_W  = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSTEPS - 1);

    red_state_e       state_q;
    logic [SC_W-1:0]  acc_q;
    logic [DIN_W-1:0] shift_q;
    logic [DIN_W-1:0] shift_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [252:0]     dout_q;
    logic             done_q;
    logic             busy_q;

    logic [SC_W-1:0]  chain_s [0:BITS_PER_CYCLE];

    assign chain_s[0] = acc_q;

    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
        sc_reduce_step u_step (
            .acc_in  (chain_s[gi]),
            .b       (shift_q[DIN_W-1-gi]),
            .acc_out (chain_s[gi+1])
        );
    end

    // Next shift-register and counter values for a RUN cycle.
    always_comb begin
        shift_d = shift_q << BITS_PER_CYCLE;
        cnt_d   = cnt_q + CNT_W'(1);
    end

    // Reducer FSM with registered dout/done/busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RED_IDLE;
            acc_q   <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end
`ifdef SC_REDUCE_ZEROIZE_EN
        else if (zeroize) begin
            state_q <= RED_IDLE;
            acc_q   <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end
`endif
        else begin
            case (state_q)
                RED_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        shift_q <= din;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RED_RUN;
                    end
                end
                RED_RUN: begin
                    acc_q   <= chain_s[BITS_PER_CYCLE];
                    shift_q <= shift_d;
                    cnt_q   <= cnt_d;
                    // Result is published on entry to FIN so done and dout line up.
                    if (cnt_q == CNT_LAST) begin
                        dout_q  <= chain_s[BITS_PER_CYCLE][252:0];
                        done_q  <= 1'b1;
                        state_q <= RED_FIN;
                    end
                end
                RED_FIN: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= RED_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= RED_IDLE;
                end
            endcase
        end
    end

    assign dout = dout_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_sc_reduce_mod_l.sv
// Self-checking bench for sc_reduce_mod_l: arithmetic reference model checked
// every cycle, plus directed vectors with hand-computed results.
module tb_sc_reduce_mod_l;

    localparam int BPC = 1;
    localparam int DW  = 512;
    localparam int NS  = DW / BPC;
    localparam logic [253:0] LREF =
        254'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [511:0] din;
    logic [252:0] dout;
    logic         done;
    logic         busy;
`ifdef SC_REDUCE_ZEROIZE_EN
    logic         zeroize;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sc_reduce_mod_l #(.DIN_W(DW), .BITS_PER_CYCLE(BPC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .din     (din),
`ifdef SC_REDUCE_ZEROIZE_EN
        .zeroize (zeroize),
`endif
        .dout    (dout),
        .done    (done),
        .busy    (busy)
    );

    function automatic logic [252:0] ref_mod(input logic [511:0] x);
        logic [511:0] r;
        r = x % {258'd0, LREF};
        return r[252:0];
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Reference model: transaction-level timing, result from plain arithmetic.
    logic         m_busy, m_done;
    logic [252:0] m_dout, m_res;
    int           m_rem;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_dout <= '0; m_res <= '0; m_rem <= 0;
        end
`ifdef SC_REDUCE_ZEROIZE_EN
        else if (zeroize) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_dout <= '0; m_rem <= 0;
        end
`endif
        else if (m_done) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
        end else if (m_busy) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                m_done <= 1'b1;
                m_dout <= m_res;
            end
        end else if (start) begin
            m_busy <= 1'b1;
            m_rem  <= NS;
            m_res  <= ref_mod(din);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_busy", {255'd0, busy}, {255'd0, m_busy});
            chk("cyc_done", {255'd0, done}, {255'd0, m_done});
            chk("cyc_dout", {3'd0, dout}, {3'd0, m_dout});
        end
    end

    task automatic wait_done(inout int cyc);
        while (!done && cyc < NS + 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_vec(input logic [511:0] d, input logic [252:0] exp, input string nm);
        int cyc;
        @(negedge clk);
        din   = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        din   = ~d;
        cyc   = 1;
        chk({nm, "_busy1"}, {255'd0, busy}, 256'd1);
        wait_done(cyc);
        chk({nm, "_lat"}, 256'(cyc), 256'(NS + 1));
        chk({nm, "_busyN"}, {255'd0, busy}, 256'd1);
        chk({nm, "_dout"}, {3'd0, dout}, {3'd0, exp});
    endtask

    initial begin
        logic [511:0] v, da, db;
        int cyc, seen;
        rst_n = 1'b0; start = 1'b0; din = '0;
`ifdef SC_REDUCE_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_dout", {3'd0, dout}, 256'd0);
        chk("rst_done", {255'd0, done}, 256'd0);
        chk("rst_busy", {255'd0, busy}, 256'd0);
        #2 rst_n = 1'b1;

        run_vec(512'd0, 253'd0, "zero");
        v = {258'd0, LREF};
        run_vec(v, 253'd0, "L");
        run_vec(v << 1, 253'd0, "2L");
        run_vec(v - 512'd1,
            253'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ec, "Lm1");
        v = '0;
        v[253] = 1'b1;
        run_vec(v,
            253'h0fffffffffffffffffffffffffffffffeb2106215d086329a7ed9ce5a30a2c13, "p253");
        v = {258'd0, LREF} * 512'd5 + 512'd7;
        run_vec(v, 253'd7, "5Lp7");

        // Start while busy is ignored; start during FIN is ignored too.
        da = {16{32'hdeadbeef}};
        db = {16{32'h12345678}};
        @(negedge clk); din = da; start = 1'b1;
        @(negedge clk); start = 1'b0; cyc = 1;
        while (cyc < 100) begin @(negedge clk); cyc++; end
        din = db; start = 1'b1;
        @(negedge clk); cyc++; start = 1'b0;
        wait_done(cyc);
        chk("ign_lat", 256'(cyc), 256'(NS + 1));
        chk("ign_dout", {3'd0, dout}, {3'd0, ref_mod(da)});
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("fin_start_busy1", {255'd0, busy}, 256'd0);
        @(negedge clk);
        chk("fin_start_busy2", {255'd0, busy}, 256'd0);

        // Reset mid-run aborts with no done.
        @(negedge clk); din = db; start = 1'b1;
        @(negedge clk); start = 1'b0; cyc = 1;
        while (cyc < 200) begin @(negedge clk); cyc++; end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_dout", {3'd0, dout}, 256'd0);
        chk("midrst_done", {255'd0, done}, 256'd0);
        chk("midrst_busy", {255'd0, busy}, 256'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        seen = 0;
        repeat (NS + 10) begin @(negedge clk); if (done) seen = 1; end
        chk("midrst_nodone", 256'(seen), 256'd0);

        for (int i = 0; i < 4; i++) begin
            for (int w = 0; w < 16; w++) v[w*32 +: 32] = $urandom;
            run_vec(v, ref_mod(v), "rand");
        end

`ifdef SC_REDUCE_ZEROIZE_EN
        @(negedge clk); din = da; start = 1'b1;
        @(negedge clk); start = 1'b0; cyc = 1;
        while (cyc < 300) begin @(negedge clk); cyc++; end
        zeroize = 1'b1;
        @(negedge clk); zeroize = 1'b0;
        chk("zer_busy", {255'd0, busy}, 256'd0);
        chk("zer_dout", {3'd0, dout}, 256'd0);
        seen = 0;
        repeat (NS + 10) begin @(negedge clk); if (done) seen = 1; end
        chk("zer_nodone", 256'(seen), 256'd0);
        zeroize = 1'b1; start = 1'b1; din = da;
        @(negedge clk); zeroize = 1'b0; start = 1'b0;
        chk("zer_start_busy1", {255'd0, busy}, 256'd0);
        @(negedge clk);
        chk("zer_start_busy2", {255'd0, busy}, 256'd0);
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
